// File: rtl/interrupt_arbiter.sv
// Single-channel interrupt arbiter: grants one pending line, runs the ack/EOI handshake, then pulses int_clr.
// Optional macro INT_ARB_RR_EN selects round-robin arbitration; otherwise the lowest index wins.
module interrupt_arbiter #(
    parameter int WIDTH    = 31,
    parameter int IDW      = 5,
    parameter int HOLD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] int_line,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic             irq,
    output logic [IDW-1:0]   irq_id,
    output logic [WIDTH-1:0] int_clr,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, REQ, SVC, CLR, HOLD} state_t;

    state_t           state, state_n;
    logic             irq_n;
    logic [IDW-1:0]   irq_id_n;
    logic [WIDTH-1:0] int_clr_n;
    logic [3:0]       cnt, cnt_n;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   search_start;

    // First set bit found scanning upward from start, wrapping at WIDTH-1.
    function automatic logic [IDW-1:0] pick(input logic [WIDTH-1:0] lines,
                                            input logic [IDW-1:0]   start);
        logic [IDW-1:0]   w;
        logic             found;
        logic [WIDTH-1:0] sh;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = int'(start) + i;
            if (idx >= WIDTH) idx = idx - WIDTH;
            sh = lines >> idx;
            if (!found && sh[0]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

`ifdef INT_ARB_RR_EN
    logic [IDW-1:0] ptr, ptr_n;
    assign search_start = ptr;
`else
    assign search_start = '0;
`endif

    assign winner = pick(int_line, search_start);

    always_comb begin
        state_n   = state;
        irq_n     = irq;
        irq_id_n  = irq_id;
        int_clr_n = '0;
        cnt_n     = cnt;
`ifdef INT_ARB_RR_EN
        ptr_n     = ptr;
`endif
        case (state)
            IDLE: begin
                if (|int_line) begin
                    irq_id_n = winner;
                    irq_n    = 1'b1;
                    state_n  = REQ;
                end
            end
            REQ: begin
                // Ack takes precedence over a simultaneous withdraw.
                if (irq_ack) begin
                    irq_n   = 1'b0;
                    state_n = SVC;
                end else if (!int_line[irq_id]) begin
                    irq_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            SVC: begin
                if (irq_eoi) begin
                    int_clr_n = WIDTH'(1) << irq_id;
                    state_n   = CLR;
`ifdef INT_ARB_RR_EN
                    ptr_n     = (irq_id == IDW'(WIDTH - 1)) ? '0 : irq_id + 1'b1;
`endif
                end
            end
            CLR: begin
                cnt_n   = 4'(HOLD_CYC);
                state_n = HOLD;
            end
            HOLD: begin
                // Gives the source time to drop its stale pending flag before rearbitration.
                cnt_n = cnt - 4'd1;
                if (cnt_n == 4'd0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
            int_clr <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
`ifdef INT_ARB_RR_EN
            ptr     <= '0;
`endif
        end else begin
            state   <= state_n;
            irq     <= irq_n;
            irq_id  <= irq_id_n;
            int_clr <= int_clr_n;
            busy    <= (state_n != IDLE);
            cnt     <= cnt_n;
`ifdef INT_ARB_RR_EN
            ptr     <= ptr_n;
`endif
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter (WIDTH=31, IDW=5, HOLD_CYC=2).
module tb_interrupt_arbiter;

    localparam int WIDTH = 31;
    localparam int IDW   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] int_line;
    logic             irq_ack;
    logic             irq_eoi;
    logic             irq;
    logic [IDW-1:0]   irq_id;
    logic [WIDTH-1:0] int_clr;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    interrupt_arbiter #(.WIDTH(WIDTH), .IDW(IDW), .HOLD_CYC(2)) dut (
        .clk(clk), .rst(rst), .int_line(int_line), .irq_ack(irq_ack), .irq_eoi(irq_eoi),
        .irq(irq), .irq_id(irq_id), .int_clr(int_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full grant/ack/EOI/hold sequence; optionally clears the serviced line after CLR.
    task automatic service(input int exp_id, input bit clear_src);
        logic [WIDTH-1:0] mask;
        mask = WIDTH'(1) << exp_id;
        tick();
        chk("svc_irq", 32'(irq), 32'd1);
        chk("svc_id", 32'(irq_id), 32'(exp_id));
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("svc_ack_irq", 32'(irq), 32'd0);
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        chk("svc_clr", 32'(int_clr), 32'(mask));
        if (clear_src) int_line = int_line & ~mask;
        tick(); tick(); tick();
        chk("svc_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; int_line = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
        tick(); tick();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_clr", 32'(int_clr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // single source, hold timing
        int_line = 31'h10;
        tick();
        chk("single_irq", 32'(irq), 32'd1);
        chk("single_id", 32'(irq_id), 32'd4);
        chk("single_busy", 32'(busy), 32'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("single_ack_irq", 32'(irq), 32'd0);
        tick();
        chk("single_svc_clr", 32'(int_clr), 32'd0);
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        chk("single_clr", 32'(int_clr), 32'h10);
        int_line = '0;
        tick();
        chk("single_clr_drop", 32'(int_clr), 32'd0);
        chk("single_hold1", 32'(busy), 32'd1);
        tick();
        chk("single_hold2", 32'(busy), 32'd1);
        tick();
        chk("single_busy_fall", 32'(busy), 32'd0);
        chk("single_id_kept", 32'(irq_id), 32'd4);

        // spurious handshakes, then reset mid-SVC
        int_line = 31'h10;
        tick();
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        chk("spur_eoi_irq", 32'(irq), 32'd1);
        chk("spur_eoi_clr", 32'(int_clr), 32'd0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("spur_ack_irq", 32'(irq), 32'd0);
        chk("spur_ack_clr", 32'(int_clr), 32'd0);
        chk("spur_ack_busy", 32'(busy), 32'd1);
        int_line = '0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_irq", 32'(irq), 32'd0);
        chk("midrst_clr", 32'(int_clr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_id", 32'(irq_id), 32'd0);
        tick();
        chk("midrst_noclr", 32'(int_clr), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

`ifdef INT_ARB_RR_EN
        int_line = 31'h4000_0003;
        service(0, 1'b0);
        service(1, 1'b0);
        service(30, 1'b0);
        service(0, 1'b0);
`else
        int_line = 31'h61;
        service(0, 1'b0);
        service(0, 1'b0);
        service(0, 1'b0);
        service(0, 1'b1);
        service(5, 1'b1);
        service(6, 1'b1);
`endif
        int_line = '0;
        tick();

        // withdraw before ack
        int_line = 31'h100;
        tick();
        chk("wd_irq", 32'(irq), 32'd1);
        chk("wd_id", 32'(irq_id), 32'd8);
        int_line = '0;
        tick();
        chk("wd_drop_irq", 32'(irq), 32'd0);
        chk("wd_drop_busy", 32'(busy), 32'd0);
        chk("wd_drop_clr", 32'(int_clr), 32'd0);
        tick();
        chk("wd_stay_irq", 32'(irq), 32'd0);

        // drop and ack on the same edge: ack wins
        int_line = 31'h100;
        tick();
        chk("wdack_id", 32'(irq_id), 32'd8);
        int_line = '0; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("wdack_irq", 32'(irq), 32'd0);
        chk("wdack_busy", 32'(busy), 32'd1);
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        chk("wdack_clr", 32'(int_clr), 32'h100);
        tick(); tick(); tick();
        chk("wdack_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
